// File: rtl/midi_framer_if.sv
// Byte-stream input and event-queue output bundle for midi_framer.
// Defining MIDI_FRAMER_CHANNEL_FILTER_EN adds the midi_channel/omni channel-select signals.
interface midi_framer_if;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       midi_event_valid;
    logic [7:0] midi_command;
    logic [6:0] midi_parameter_1;
    logic [6:0] midi_parameter_2;
    logic       midi_event_ack;
    logic       overflow;
`ifdef MIDI_FRAMER_CHANNEL_FILTER_EN
    logic [3:0] midi_channel;
    logic       omni;

    modport slave (
        input  byte_data, byte_valid, midi_event_ack, midi_channel, omni,
        output midi_event_valid, midi_command, midi_parameter_1,
               midi_parameter_2, overflow
    );

    modport master (
        output byte_data, byte_valid, midi_event_ack, midi_channel, omni,
        input  midi_event_valid, midi_command, midi_parameter_1,
               midi_parameter_2, overflow
    );
`else
    modport slave (
        input  byte_data, byte_valid, midi_event_ack,
        output midi_event_valid, midi_command, midi_parameter_1,
               midi_parameter_2, overflow
    );

    modport master (
        output byte_data, byte_valid, midi_event_ack,
        input  midi_event_valid, midi_command, midi_parameter_1,
               midi_parameter_2, overflow
    );
`endif
endinterface

// File: rtl/midi_framer.sv
// MIDI byte-stream framer: assembles channel-voice events and queues them for the consumer.
// Optional channel filtering is enabled by defining MIDI_FRAMER_CHANNEL_FILTER_EN.
module midi_framer #(
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    midi_framer_if.slave bus
);
    localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_P1,
        WAIT_P2,
        SYSEX,
        SKIP_COMMON
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  status_q, status_d;
    logic [6:0]  p1_q, p1_d;
    logic [1:0]  skip_q, skip_d;

    logic        is_realtime;
    logic        evt_done;
    logic [6:0]  evt_p1;
    logic [6:0]  evt_p2;
    logic [7:0]  norm_cmd;
    logic [6:0]  norm_p2;
    logic        chan_ok;
    logic        accept;

    logic [21:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0] count_q;
    logic        overflow_q;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        drop;
    logic [21:0] head;

    assign is_realtime = (bus.byte_data >= 8'hF8);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            status_q <= 8'h00;
            p1_q     <= 7'h00;
            skip_q   <= 2'd0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            p1_q     <= p1_d;
            skip_q   <= skip_d;
        end
    end

    // Every non-realtime status byte is handled identically in all states, which also ends SysEx.
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        p1_d     = p1_q;
        skip_d   = skip_q;
        evt_done = 1'b0;
        evt_p1   = p1_q;
        evt_p2   = 7'h00;

        if (bus.byte_valid && !is_realtime) begin
            if (bus.byte_data[7]) begin
                if (bus.byte_data < 8'hF0) begin
                    status_d = bus.byte_data;
                    state_d  = WAIT_P1;
                end else begin
                    status_d = 8'h00;
                    case (bus.byte_data)
                        8'hF0: state_d = SYSEX;
                        8'hF1, 8'hF3: begin
                            state_d = SKIP_COMMON;
                            skip_d  = 2'd1;
                        end
                        8'hF2: begin
                            state_d = SKIP_COMMON;
                            skip_d  = 2'd2;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end else begin
                case (state_q)
                    WAIT_P1: begin
                        p1_d = bus.byte_data[6:0];
                        if (status_q[7:5] == 3'b110) begin
                            evt_done = 1'b1;
                            evt_p1   = bus.byte_data[6:0];
                        end else begin
                            state_d = WAIT_P2;
                        end
                    end
                    WAIT_P2: begin
                        evt_done = 1'b1;
                        evt_p2   = bus.byte_data[6:0];
                        state_d  = WAIT_P1;
                    end
                    SKIP_COMMON: begin
                        skip_d = skip_q - 2'd1;
                        if (skip_q <= 2'd1) begin
                            state_d = IDLE;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Note On with velocity 0 is reported as Note Off with the default release velocity.
    always_comb begin
        norm_cmd = status_q;
        norm_p2  = evt_p2;
        if ((status_q[7:4] == 4'h9) && (evt_p2 == 7'h00)) begin
            norm_cmd = {4'h8, status_q[3:0]};
            norm_p2  = 7'h40;
        end
    end

`ifdef MIDI_FRAMER_CHANNEL_FILTER_EN
    assign chan_ok = bus.omni || (status_q[3:0] == bus.midi_channel);
`else
    assign chan_ok = 1'b1;
`endif

    assign accept = evt_done && chan_ok;
    assign empty  = (count_q == '0);
    assign full   = (count_q == DEPTH_C);
    assign pop    = !empty && bus.midi_event_ack;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + (PW + 1)'(1);
            end else if (pop && !push) begin
                count_q <= count_q - (PW + 1)'(1);
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Queue storage needs no reset: the outputs are masked whenever the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {norm_cmd, evt_p1, norm_p2};
        end
    end

    assign head                 = mem_q[rd_ptr_q];
    assign bus.midi_event_valid = !empty;
    assign bus.midi_command     = empty ? 8'h00 : head[21:14];
    assign bus.midi_parameter_1 = empty ? 7'h00 : head[13:7];
    assign bus.midi_parameter_2 = empty ? 7'h00 : head[6:0];
    assign bus.overflow         = overflow_q;

endmodule

// File: tb/tb_midi_framer.sv
// Directed self-checking bench for midi_framer (FIFO_DEPTH=4).
// Channel-filter checks run only when MIDI_FRAMER_CHANNEL_FILTER_EN is defined.
module tb_midi_framer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    midi_framer_if bus ();

    midi_framer #(.FIFO_DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic v, input logic [7:0] cmd,
                               input logic [6:0] p1, input logic [6:0] p2);
        check({tag, "_valid"}, 32'(bus.midi_event_valid), 32'(v));
        check({tag, "_cmd"},   32'(bus.midi_command),     32'(cmd));
        check({tag, "_p1"},    32'(bus.midi_parameter_1), 32'(p1));
        check({tag, "_p2"},    32'(bus.midi_parameter_2), 32'(p2));
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        bus.byte_data  = b;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
    endtask

    task automatic ackOne();
        @(negedge clk);
        bus.midi_event_ack = 1'b1;
        @(negedge clk);
        bus.midi_event_ack = 1'b0;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.byte_data      = 8'h00;
        bus.byte_valid     = 1'b0;
        bus.midi_event_ack = 1'b0;
`ifdef MIDI_FRAMER_CHANNEL_FILTER_EN
        bus.midi_channel   = 4'd0;
        bus.omni           = 1'b1;
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset", 1'b0, 8'h00, 7'h00, 7'h00);
        check("reset_ovf", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;

        $display("[TB] single note on");
        applyStimulus(8'h90);
        applyStimulus(8'h3C);
        check("t1_prevalid", 32'(bus.midi_event_valid), 32'd0);
        applyStimulus(8'h64);
        checkOutput("t1_evt", 1'b1, 8'h90, 7'h3C, 7'h64);
        ackOne();
        checkOutput("t1_popped", 1'b0, 8'h00, 7'h00, 7'h00);

        $display("[TB] running status and velocity-zero normalisation");
        applyStimulus(8'h90);
        applyStimulus(8'h3C);
        applyStimulus(8'h64);
        applyStimulus(8'h40);
        applyStimulus(8'h50);
        checkOutput("t2_evt0", 1'b1, 8'h90, 7'h3C, 7'h64);
        ackOne();
        checkOutput("t2_evt1", 1'b1, 8'h90, 7'h40, 7'h50);
        ackOne();
        check("t2_empty", 32'(bus.midi_event_valid), 32'd0);
        applyStimulus(8'h3C);
        applyStimulus(8'h00);
        checkOutput("t2_noteoff", 1'b1, 8'h80, 7'h3C, 7'h40);
        ackOne();

        $display("[TB] realtime, program change and sysex");
        applyStimulus(8'hB0);
        applyStimulus(8'h01);
        applyStimulus(8'hF8);
        applyStimulus(8'h7F);
        checkOutput("t3_cc", 1'b1, 8'hB0, 7'h01, 7'h7F);
        ackOne();
        applyStimulus(8'hC2);
        applyStimulus(8'h05);
        checkOutput("t3_pc", 1'b1, 8'hC2, 7'h05, 7'h00);
        ackOne();
        check("t3_pc_popped", 32'(bus.midi_event_valid), 32'd0);
        applyStimulus(8'hF0);
        applyStimulus(8'h12);
        applyStimulus(8'h34);
        applyStimulus(8'hF7);
        applyStimulus(8'h22);
        @(negedge clk);
        check("t3_sysex_none", 32'(bus.midi_event_valid), 32'd0);

        $display("[TB] overflow");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(8'h90);
            applyStimulus(8'h30 + 8'(i));
            applyStimulus(8'h10 + 8'(i));
        end
        check("t4_ovf_set", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t4_drain%0d", i), 1'b1, 8'h90, 7'h30 + 7'(i), 7'h10 + 7'(i));
            ackOne();
        end
        check("t4_drained", 32'(bus.midi_event_valid), 32'd0);
        check("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

        $display("[TB] mid-message reset");
        applyStimulus(8'h90);
        applyStimulus(8'h3C);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_inreset", 1'b0, 8'h00, 7'h00, 7'h00);
        check("t5_ovf_cleared", 32'(bus.overflow), 32'd0);
        rst_n = 1'b1;
        applyStimulus(8'h64);
        @(negedge clk);
        check("t5_no_event", 32'(bus.midi_event_valid), 32'd0);

        $display("[TB] simultaneous enqueue and pop on a full queue");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'h90);
            applyStimulus(8'h30 + 8'(i));
            applyStimulus(8'h10 + 8'(i));
        end
        applyStimulus(8'h90);
        applyStimulus(8'h44);
        @(negedge clk);
        bus.byte_data      = 8'h55;
        bus.byte_valid     = 1'b1;
        bus.midi_event_ack = 1'b1;
        @(negedge clk);
        bus.byte_valid     = 1'b0;
        bus.byte_data      = 8'h00;
        bus.midi_event_ack = 1'b0;
        check("t6_no_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 1; i < 4; i++) begin
            checkOutput($sformatf("t6_drain%0d", i), 1'b1, 8'h90, 7'h30 + 7'(i), 7'h10 + 7'(i));
            ackOne();
        end
        checkOutput("t6_new", 1'b1, 8'h90, 7'h44, 7'h55);
        ackOne();
        check("t6_empty", 32'(bus.midi_event_valid), 32'd0);

`ifdef MIDI_FRAMER_CHANNEL_FILTER_EN
        $display("[TB] channel filter");
        bus.omni         = 1'b0;
        bus.midi_channel = 4'd2;
        applyStimulus(8'h93);
        applyStimulus(8'h3C);
        applyStimulus(8'h64);
        @(negedge clk);
        check("t7_filtered", 32'(bus.midi_event_valid), 32'd0);
        applyStimulus(8'h92);
        applyStimulus(8'h3C);
        applyStimulus(8'h64);
        checkOutput("t7_pass", 1'b1, 8'h92, 7'h3C, 7'h64);
        check("t7_no_ovf", 32'(bus.overflow), 32'd0);
        ackOne();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
